// File: rtl/wbdepp_bridge.sv
// DEPP host port to pipelined Wishbone master bridge with byte-lane address/data
// registers, streaming data index, optional address auto-increment, error and timeout status.
module wbdepp_bridge #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TMO_CYCLES  = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_astb_n,
  input  logic          i_dstb_n,
  input  logic          i_write_n,
  input  logic [7:0]    i_depp,
  output logic [7:0]    o_depp,
  output logic          o_wait,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_int
);
  localparam int NA = AW / 8;
  localparam int NB = DW / 8;
  localparam int TW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AREG   = 3'd1,
    DREG   = 3'd2,
    WBREQ  = 3'd3,
    WBWAIT = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t state_r, state_next_s;

  // Lane order in each stage: {int, write_n, dstb_n, astb_n}
  logic [SYNC_STAGES-1:0][3:0] sync_r;
  logic astb_prev_r, dstb_prev_r, act_dstb_r, dstb_pend_r;
  logic err_r, tmo_r, autoinc_r;
  logic [7:0]    idx_r;
  logic [DW-1:0] data_r;
  logic [TW-1:0] tmo_cnt_r;

  logic astb_s, dstb_s, write_s, int_s, astb_fall_s, dstb_fall_s, hold_rel_s;
  logic is_addr_s, is_data_s, wb_wr_s, wb_rd_s;
  logic wb_active_s, ack_s, err_s, tmo_hit_s, done_s;
  logic [7:0]    status_s, rd_byte_s, idx_adv_s;
  logic [DW-1:0] wr_word_s;
  logic [AW-1:0] addr_wr_s;

  assign astb_s      = sync_r[SYNC_STAGES-1][0];
  assign dstb_s      = sync_r[SYNC_STAGES-1][1];
  assign write_s     = ~sync_r[SYNC_STAGES-1][2];
  assign int_s       = sync_r[SYNC_STAGES-1][3];
  assign astb_fall_s = astb_prev_r & ~astb_s;
  assign dstb_fall_s = dstb_prev_r & ~dstb_s;
  assign hold_rel_s  = act_dstb_r ? dstb_s : astb_s;

  assign is_addr_s = (idx_r < 8'(NA));
  assign is_data_s = (idx_r >= 8'd4) && (idx_r < 8'(4 + NB));
  assign wb_wr_s   = write_s && (idx_r == 8'(4 + NB - 1));
  assign wb_rd_s   = !write_s && (idx_r == 8'd4);
  assign idx_adv_s = (idx_r == 8'(4 + NB - 1)) ? 8'd4 : idx_r + 8'd1;

  assign wb_active_s = (state_r == WBREQ) || (state_r == WBWAIT);
  assign ack_s       = wb_active_s && i_wb_ack && !i_wb_err;
  assign err_s       = wb_active_s && i_wb_err;
  assign tmo_hit_s   = wb_active_s && !i_wb_ack && !i_wb_err && (tmo_cnt_r == TW'(TMO_CYCLES - 1));
  assign done_s      = ack_s || err_s || tmo_hit_s;

  assign status_s = {3'b000, o_wb_cyc, autoinc_r, int_s, tmo_r, err_r};
  assign o_wb_sel = {NB{1'b1}};

  // Host register read mux and byte-lane merge of the incoming host byte
  always_comb begin
    rd_byte_s = 8'h00;
    wr_word_s = data_r;
    addr_wr_s = o_wb_addr;
    for (int b = 0; b < NA; b++) begin
      rd_byte_s = (idx_r == 8'(b)) ? o_wb_addr[8*b +: 8] : rd_byte_s;
      addr_wr_s[8*b +: 8] = (idx_r == 8'(b)) ? i_depp : o_wb_addr[8*b +: 8];
    end
    for (int b = 0; b < NB; b++) begin
      rd_byte_s = (idx_r == 8'(4 + b)) ? data_r[8*b +: 8] : rd_byte_s;
      wr_word_s[8*b +: 8] = (idx_r == 8'(4 + b)) ? i_depp : data_r[8*b +: 8];
    end
    rd_byte_s = (idx_r == 8'd8) ? status_s : rd_byte_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (astb_fall_s) begin
          state_next_s = AREG;
        end else if (dstb_fall_s || (dstb_pend_r && !dstb_s)) begin
          state_next_s = DREG;
        end else begin
          state_next_s = IDLE;
        end
      end
      AREG:   state_next_s = HOLD;
      DREG:   state_next_s = (wb_wr_s || wb_rd_s) ? WBREQ : HOLD;
      WBREQ: begin
        if (done_s) begin
          state_next_s = HOLD;
        end else if (!i_wb_stall) begin
          state_next_s = WBWAIT;
        end else begin
          state_next_s = WBREQ;
        end
      end
      WBWAIT: state_next_s = done_s ? HOLD : WBWAIT;
      HOLD:   state_next_s = hold_rel_s ? IDLE : HOLD;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Synchronisers, host registers and Wishbone master datapath
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_r      <= {SYNC_STAGES{4'b0111}};
      astb_prev_r <= 1'b1;
      dstb_prev_r <= 1'b1;
      act_dstb_r  <= 1'b0;
      dstb_pend_r <= 1'b0;
      err_r       <= 1'b0;
      tmo_r       <= 1'b0;
      autoinc_r   <= 1'b0;
      idx_r       <= 8'h00;
      data_r      <= '0;
      tmo_cnt_r   <= '0;
      o_depp      <= 8'h00;
      o_wait      <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], i_int, i_write_n, i_dstb_n, i_astb_n};
      astb_prev_r <= astb_s;
      dstb_prev_r <= dstb_s;
      o_wait      <= (state_next_s == HOLD);
      if (state_r == IDLE) begin
        dstb_pend_r <= astb_fall_s && dstb_fall_s;
      end
      case (state_r)
        AREG: begin
          act_dstb_r <= 1'b0;
          if (write_s) begin
            idx_r <= i_depp;
          end else begin
            o_depp <= idx_r;
          end
        end
        DREG: begin
          act_dstb_r <= 1'b1;
          if (is_data_s) begin
            idx_r <= idx_adv_s;
          end
          if (write_s) begin
            if (is_addr_s) o_wb_addr <= addr_wr_s;
            if (is_data_s) data_r <= wr_word_s;
            if (idx_r == 8'd8) begin
              autoinc_r <= i_depp[3];
              if (i_depp[0]) err_r <= 1'b0;
              if (i_depp[1]) tmo_r <= 1'b0;
            end
          end else if (!wb_rd_s) begin
            o_depp <= rd_byte_s;
          end
          if (wb_wr_s || wb_rd_s) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= wb_wr_s;
            tmo_cnt_r <= '0;
          end
          if (wb_wr_s) o_wb_data <= wr_word_s;
        end
        WBREQ, WBWAIT: begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
          if (!i_wb_stall) o_wb_stb <= 1'b0;
          if (done_s) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            if (ack_s) begin
              if (!o_wb_we) begin
                data_r <= i_wb_data;
                o_depp <= i_wb_data[7:0];
              end
              if (autoinc_r) o_wb_addr <= o_wb_addr + {{(AW-1){1'b0}}, 1'b1};
            end else begin
              // Abort: error and timeout both return zero read data
              if (err_s) begin
                err_r <= 1'b1;
              end else begin
                tmo_r <= 1'b1;
              end
              if (!o_wb_we) begin
                data_r <= '0;
                o_depp <= 8'h00;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wbdepp_bridge.sv
// Directed self-checking bench for wbdepp_bridge: DEPP host tasks, a configurable
// Wishbone slave responder and a bus monitor feed hand-computed comparisons.
module tb_wbdepp_bridge;
  logic        clk = 1'b0;
  logic        i_reset_n, i_astb_n, i_dstb_n, i_write_n, i_int;
  logic [7:0]  i_depp, o_depp;
  logic        o_wait, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data, i_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall, i_wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave responder configuration: mode 0 = ack, 1 = err, 2 = silent
  int          cfg_stall = 0;
  int          cfg_dly   = 0;
  int          cfg_mode  = 0;
  logic [31:0] cfg_rdata = 32'h0;
  bit          slave_en  = 1'b1;
  int          sl_seen, sl_left, sl_phase;

  int   cyc_rises = 0, cyc_run = 0, cyc_last = 0, stb_run = 0, stb_last = 0;
  logic cyc_q = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];

  logic [7:0] d;
  int         lat, r0, n;
  logic [7:0] abytes[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] sbytes[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] rbytes[3] = '{8'hF0, 8'hFE, 8'hCA};
  logic [7:0] ebytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  wbdepp_bridge #(.AW(32), .DW(32), .TMO_CYCLES(15), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_astb_n(i_astb_n), .i_dstb_n(i_dstb_n),
    .i_write_n(i_write_n), .i_depp(i_depp), .o_depp(o_depp), .o_wait(o_wait),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_err(i_wb_err), .i_wb_data(i_wb_data), .i_int(i_int)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic respond();
    case (cfg_mode)
      0: begin i_wb_ack = 1'b1; i_wb_data = cfg_rdata; end
      1: i_wb_err = 1'b1;
      default: ;
    endcase
  endtask

  // One host strobe cycle; lat counts clock edges from strobe fall to o_wait high
  task automatic depp(input bit is_data, input bit wr, input logic [7:0] din, input int budget,
                      output logic [7:0] dout, output int lat_o);
    int k;
    @(negedge clk);
    i_write_n = !wr;
    i_depp    = din;
    if (is_data) i_dstb_n = 1'b0; else i_astb_n = 1'b0;
    lat_o = 0;
    while (o_wait !== 1'b1 && lat_o < budget) begin
      @(posedge clk); #1; lat_o++;
    end
    check_eq("wait_hi", o_wait, 1'b1);
    dout = o_depp;
    @(negedge clk);
    i_astb_n = 1'b1;
    i_dstb_n = 1'b1;
    k = 0;
    while (o_wait !== 1'b0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check_eq("wait_lo", o_wait, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Bus monitor: cycle count, cyc/stb run lengths, accepted requests
  always @(posedge clk) begin
    cyc_q     <= o_wb_cyc;
    cyc_rises <= cyc_rises + ((o_wb_cyc && !cyc_q) ? 1 : 0);
    cyc_run   <= o_wb_cyc ? cyc_run + 1 : 0;
    stb_run   <= o_wb_stb ? stb_run + 1 : 0;
    if (!o_wb_cyc && cyc_run > 0) cyc_last <= cyc_run;
    if (!o_wb_stb && stb_run > 0) stb_last <= stb_run;
    if (i_reset_n && o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      log_addr.push_back(o_wb_addr);
      log_data.push_back(o_wb_data);
      log_we.push_back(o_wb_we);
      log_sel.push_back(o_wb_sel);
    end
  end

  // Wishbone slave: stalls cfg_stall edges, responds cfg_dly edges after accept
  initial begin
    sl_seen = 0; sl_left = 0; sl_phase = 0;
    forever begin
      @(posedge clk); #1;
      if (slave_en) begin
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (!o_wb_cyc) begin
          sl_seen = 0; sl_phase = 0;
          i_wb_stall = (cfg_stall != 0);
        end else if (sl_phase == 0) begin
          sl_seen++;
          if (sl_seen <= cfg_stall) begin
            i_wb_stall = 1'b1;
          end else begin
            i_wb_stall = 1'b0;
            sl_phase = 1;
            sl_left = cfg_dly;
            if (sl_left == 0) begin respond(); sl_phase = 2; end
          end
        end else if (sl_phase == 1) begin
          sl_left--;
          if (sl_left == 0) begin respond(); sl_phase = 2; end
        end
      end
    end
  end

  initial begin
    i_reset_n = 1'b0; i_astb_n = 1'b1; i_dstb_n = 1'b1; i_write_n = 1'b1;
    i_depp = 8'h00; i_int = 1'b0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_wait", o_wait, 1'b0);
    check_eq("rst_depp", o_depp, 8'h00);
    check_eq("rst_cyc", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
    check_eq("rst_addr", o_wb_addr, 32'h0);
    check_eq("rst_data", o_wb_data, 32'h0);
    check_eq("rst_sel", o_wb_sel, 4'hF);
    i_reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Register path: one address byte per index
    for (int i = 0; i < 4; i++) begin
      depp(1'b0, 1'b1, 8'(i), 20, d, lat);
      check_eq("lat_astb", lat, 4);
      depp(1'b1, 1'b1, abytes[i], 20, d, lat);
      check_eq("lat_dstb", lat, 4);
    end
    check_eq("addr_reg", o_wb_addr, 32'h40302010);
    check_eq("no_cyc", cyc_rises, 0);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("idx_no_adv", d, 8'h40);
    depp(1'b0, 1'b0, 8'h00, 20, d, lat);
    check_eq("idx_read", d, 8'h03);

    // Streamed writes with autoinc
    depp(1'b0, 1'b1, 8'h08, 20, d, lat);
    depp(1'b1, 1'b1, 8'h08, 20, d, lat);
    depp(1'b0, 1'b1, 8'h04, 20, d, lat);
    for (int i = 0; i < 8; i++) begin
      depp(1'b1, 1'b1, sbytes[i], 40, d, lat);
      if (i == 3) check_eq("lat_wb", lat, 5);
    end
    check_eq("wr_count", log_addr.size(), 2);
    check_eq("wr0_addr", log_addr[0], 32'h40302010);
    check_eq("wr0_data", log_data[0], 32'hEFBEADDE);
    check_eq("wr0_we", log_we[0], 1'b1);
    check_eq("wr0_sel", log_sel[0], 4'hF);
    check_eq("wr1_addr", log_addr[1], 32'h40302011);
    check_eq("wr1_data", log_data[1], 32'h04030201);
    check_eq("addr_inc", o_wb_addr, 32'h40302012);
    depp(1'b0, 1'b1, 8'h08, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("stat_autoinc", d, 8'h08);

    // Stalled read, ack two clocks after accept
    cfg_stall = 3; cfg_dly = 2; cfg_rdata = 32'hCAFEF00D;
    r0 = cyc_rises;
    depp(1'b0, 1'b1, 8'h04, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 60, d, lat);
    check_eq("rd_b0", d, 8'h0D);
    check_eq("stb_len", stb_last, 4);
    check_eq("rd_addr", log_addr[log_addr.size()-1], 32'h40302012);
    check_eq("rd_we", log_we[log_we.size()-1], 1'b0);
    for (int i = 0; i < 3; i++) begin
      depp(1'b1, 1'b0, 8'h00, 20, d, lat);
      check_eq("rd_bk", d, rbytes[i]);
    end
    check_eq("rd_one_cyc", cyc_rises - r0, 1);
    check_eq("rd_addr_inc", o_wb_addr, 32'h40302013);
    cfg_stall = 0;

    // Bus error on a write
    cfg_mode = 1; cfg_dly = 1;
    depp(1'b0, 1'b1, 8'h04, 20, d, lat);
    for (int i = 0; i < 4; i++) depp(1'b1, 1'b1, ebytes[i], 40, d, lat);
    check_eq("err_cyc", o_wb_cyc, 1'b0);
    check_eq("err_addr", o_wb_addr, 32'h40302013);
    depp(1'b0, 1'b1, 8'h08, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("stat_err", d, 8'h09);
    depp(1'b1, 1'b1, 8'h09, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("stat_err_clr", d, 8'h08);

    // Timeout on a read
    cfg_mode = 2;
    depp(1'b0, 1'b1, 8'h04, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 80, d, lat);
    check_eq("tmo_rd", d, 8'h00);
    check_eq("tmo_len", cyc_last, 15);
    check_eq("tmo_addr", o_wb_addr, 32'h40302013);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("tmo_rd_b1", d, 8'h00);
    i_int = 1'b1;
    depp(1'b0, 1'b1, 8'h08, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("stat_tmo", d, 8'h0E);
    depp(1'b1, 1'b1, 8'h0A, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("stat_tmo_clr", d, 8'h0C);

    // Reset while a cycle is open
    depp(1'b0, 1'b1, 8'h04, 20, d, lat);
    @(negedge clk);
    i_write_n = 1'b1;
    i_dstb_n  = 1'b0;
    n = 0;
    while (o_wb_cyc !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("mid_cyc_up", o_wb_cyc, 1'b1);
    @(negedge clk);
    i_reset_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_cyc", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
    check_eq("mid_rst_addr", o_wb_addr, 32'h0);
    check_eq("mid_rst_data", o_wb_data, 32'h0);
    check_eq("mid_rst_wait", o_wait, 1'b0);
    check_eq("mid_rst_depp", o_depp, 8'h00);
    check_eq("mid_rst_sel", o_wb_sel, 4'hF);
    @(negedge clk);
    i_dstb_n = 1'b1;
    slave_en = 1'b0;
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    i_wb_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("late_ack_cyc", o_wb_cyc, 1'b0);
    check_eq("late_ack_wait", o_wait, 1'b0);
    check_eq("late_ack_addr", o_wb_addr, 32'h0);
    depp(1'b0, 1'b1, 8'h00, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("post_rst_addr", d, 8'h00);
    depp(1'b0, 1'b1, 8'h08, 20, d, lat);
    depp(1'b1, 1'b0, 8'h00, 20, d, lat);
    check_eq("post_rst_stat", d, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
